sa_inst_sequencer: RTL and testbench

Hardware instruction issuer for SYSTOLIC_ARRAY. It accepts loop descriptors into a small FIFO and expands each into COUNT instructions with independently strided ADDRA/ADDRB. Each instruction is paced by the array's flag handshake, and an optional IDLE instruction is appended after each descriptor. It sits between the host/control path and the SYSTOLIC_ARRAY `instruction` port, replacing software-driven instruction stepping.

---
 rtl/sa_inst_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_sa_inst_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_inst_sequencer.sv
// Instruction issuer for SYSTOLIC_ARRAY: expands queued loop descriptors into
// strided {opcode, addra, addrb} instructions paced by the array flag handshake.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no descriptor active, driving the idle instruction
// LOAD     | popping the FIFO head into the working registers
// ISSUE    | instruction presented, waiting for flag high (latched)
// ACK      | waiting for flag low; with hold set, advanced and paused
// WAITB    | after iteration 0, waiting for idle_flag low
// TAIL     | idle tail instruction presented, waiting for flag high
// TAIL_ACK | idle tail latched, waiting for flag low
module sa_inst_sequencer #(
    parameter int OPCODE_BITS = 4,
    parameter int ADDR_BITS   = 16,
    parameter int COUNT_BITS  = 10,
    parameter int DESC_DEPTH  = 8,
    parameter int IDLE_OPCODE = 0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               desc_valid,
    output logic                               desc_ready,
    input  logic [OPCODE_BITS-1:0]             desc_opcode,
    input  logic [COUNT_BITS-1:0]              desc_count,
    input  logic [ADDR_BITS-1:0]               desc_addra_base,
    input  logic [ADDR_BITS-1:0]               desc_addrb_base,
    input  logic [ADDR_BITS-1:0]               desc_addra_stride,
    input  logic [ADDR_BITS-1:0]               desc_addrb_stride,
    input  logic                               desc_wait_busy,
    input  logic                               desc_idle_tail,
    input  logic                               pause,
    input  logic                               flag,
    input  logic                               idle_flag,
    output logic [OPCODE_BITS+2*ADDR_BITS-1:0] instruction,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(DESC_DEPTH):0]        fifo_level
);

    localparam int PTR_BITS   = $clog2(DESC_DEPTH);
    localparam int LVL_BITS   = PTR_BITS + 1;
    localparam int INSTR_BITS = OPCODE_BITS + 2 * ADDR_BITS;
    localparam logic [OPCODE_BITS-1:0] IDLE_OP    = OPCODE_BITS'(IDLE_OPCODE);
    localparam logic [INSTR_BITS-1:0]  IDLE_INSTR = {IDLE_OP, {(2*ADDR_BITS){1'b0}}};

    typedef struct packed {
        logic [OPCODE_BITS-1:0] opcode;
        logic [COUNT_BITS-1:0]  count;
        logic [ADDR_BITS-1:0]   addra_base;
        logic [ADDR_BITS-1:0]   addrb_base;
        logic [ADDR_BITS-1:0]   addra_stride;
        logic [ADDR_BITS-1:0]   addrb_stride;
        logic                   wait_busy;
        logic                   idle_tail;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_ACK,
        S_WAITB,
        S_TAIL,
        S_TAIL_ACK
    } state_t;

    desc_t                 fifo_mem [DESC_DEPTH];
    desc_t                 desc_in;
    desc_t                 head;
    logic [PTR_BITS-1:0]   wr_ptr_q;
    logic [PTR_BITS-1:0]   rd_ptr_q;
    logic [LVL_BITS-1:0]   level_q;
    logic                  push;
    logic                  pop;

    state_t                state_q;
    state_t                state_next;
    state_t                after_done;
    logic [INSTR_BITS-1:0] instr_q;
    logic [INSTR_BITS-1:0] instr_next;
    logic                  done_q;
    logic                  done_next;
    logic                  hold_q;
    logic                  hold_next;
    logic                  step;
    logic                  do_cont;

    logic [OPCODE_BITS-1:0] op_q;
    logic [COUNT_BITS-1:0]  remaining_q;
    logic [ADDR_BITS-1:0]   a_q;
    logic [ADDR_BITS-1:0]   b_q;
    logic [ADDR_BITS-1:0]   a_stride_q;
    logic [ADDR_BITS-1:0]   b_stride_q;
    logic                   wait_busy_q;
    logic                   idle_tail_q;
    logic                   first_q;

    logic [COUNT_BITS-1:0]  rem_dec;
    logic [ADDR_BITS-1:0]   a_inc;
    logic [ADDR_BITS-1:0]   b_inc;
    logic [COUNT_BITS-1:0]  rem_cur;
    logic [ADDR_BITS-1:0]   a_cur;
    logic [ADDR_BITS-1:0]   b_cur;

    assign desc_in = '{
        opcode:       desc_opcode,
        count:        desc_count,
        addra_base:   desc_addra_base,
        addrb_base:   desc_addrb_base,
        addra_stride: desc_addra_stride,
        addrb_stride: desc_addrb_stride,
        wait_busy:    desc_wait_busy,
        idle_tail:    desc_idle_tail
    };

    assign desc_ready = (level_q != LVL_BITS'(DESC_DEPTH));
    assign push       = desc_valid && desc_ready;
    assign pop        = (state_q == S_LOAD);
    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_level = level_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= desc_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_BITS'(1);
                2'b01:   level_q <= level_q - LVL_BITS'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Strides are two's complement, so a plain modular add covers negative steps.
    assign rem_dec = remaining_q - COUNT_BITS'(1);
    assign a_inc   = a_q + a_stride_q;
    assign b_inc   = b_q + b_stride_q;

    // Back-to-back descriptors skip IDLE so the next LOAD lines up with done.
    assign after_done = ((level_q != '0) && !pause) ? S_LOAD : S_IDLE;

    always_comb begin
        state_next = state_q;
        instr_next = instr_q;
        hold_next  = hold_q;
        done_next  = 1'b0;
        step       = 1'b0;
        do_cont    = 1'b0;
        rem_cur    = remaining_q;
        a_cur      = a_q;
        b_cur      = b_q;

        case (state_q)
            S_IDLE: begin
                instr_next = IDLE_INSTR;
                if ((level_q != '0) && !pause) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (head.count == '0) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                    instr_next = IDLE_INSTR;
                end else begin
                    state_next = S_ISSUE;
                    instr_next = {head.opcode, head.addra_base, head.addrb_base};
                end
            end
            S_ISSUE: begin
                if (flag) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (hold_q) begin
                    if (!pause) begin
                        hold_next  = 1'b0;
                        state_next = S_ISSUE;
                        instr_next = {op_q, a_q, b_q};
                    end
                end else if (!flag) begin
                    step = 1'b1;
                    if (first_q && wait_busy_q) begin
                        state_next = S_WAITB;
                        instr_next = IDLE_INSTR;
                    end else begin
                        do_cont = 1'b1;
                        rem_cur = rem_dec;
                        a_cur   = a_inc;
                        b_cur   = b_inc;
                    end
                end
            end
            S_WAITB: begin
                instr_next = IDLE_INSTR;
                if (!idle_flag) begin
                    do_cont = 1'b1;
                end
            end
            S_TAIL: begin
                if (flag) begin
                    state_next = S_TAIL_ACK;
                end
            end
            S_TAIL_ACK: begin
                if (!flag) begin
                    done_next  = 1'b1;
                    state_next = after_done;
                    instr_next = IDLE_INSTR;
                end
            end
            default: begin
                state_next = S_IDLE;
                instr_next = IDLE_INSTR;
            end
        endcase

        // Shared continuation after an acknowledge (or after WAITB releases).
        if (do_cont) begin
            if (rem_cur != '0) begin
                if (pause) begin
                    state_next = S_ACK;
                    hold_next  = 1'b1;
                    instr_next = IDLE_INSTR;
                end else begin
                    state_next = S_ISSUE;
                    instr_next = {op_q, a_cur, b_cur};
                end
            end else if (idle_tail_q) begin
                state_next = S_TAIL;
                instr_next = IDLE_INSTR;
            end else begin
                done_next  = 1'b1;
                state_next = after_done;
                instr_next = IDLE_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            instr_q <= IDLE_INSTR;
            done_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            instr_q <= instr_next;
            done_q  <= done_next;
            hold_q  <= hold_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= '0;
            remaining_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            a_stride_q  <= '0;
            b_stride_q  <= '0;
            wait_busy_q <= 1'b0;
            idle_tail_q <= 1'b0;
            first_q     <= 1'b0;
        end else if (pop) begin
            op_q        <= head.opcode;
            remaining_q <= head.count;
            a_q         <= head.addra_base;
            b_q         <= head.addrb_base;
            a_stride_q  <= head.addra_stride;
            b_stride_q  <= head.addrb_stride;
            wait_busy_q <= head.wait_busy;
            idle_tail_q <= head.idle_tail;
            first_q     <= 1'b1;
        end else if (step) begin
            remaining_q <= rem_dec;
            a_q         <= a_inc;
            b_q         <= b_inc;
            first_q     <= 1'b0;
        end
    end

    assign instruction = instr_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_sa_inst_sequencer.sv
// Scoreboard bench for sa_inst_sequencer: expected instructions come from an
// arithmetic model of each descriptor; a monitor checks what the array latches.
module tb_sa_inst_sequencer;
    localparam int OPB   = 4;
    localparam int AB    = 16;
    localparam int CB    = 10;
    localparam int DEPTH = 8;
    localparam int IW    = OPB + 2 * AB;
    localparam logic [OPB-1:0] IDLE_OP = '0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          desc_valid = 1'b0;
    logic          desc_ready;
    logic [OPB-1:0] desc_opcode = '0;
    logic [CB-1:0]  desc_count = '0;
    logic [AB-1:0]  desc_addra_base = '0;
    logic [AB-1:0]  desc_addrb_base = '0;
    logic [AB-1:0]  desc_addra_stride = '0;
    logic [AB-1:0]  desc_addrb_stride = '0;
    logic          desc_wait_busy = 1'b0;
    logic          desc_idle_tail = 1'b0;
    logic          pause;
    logic          flag = 1'b0;
    logic          idle_flag;
    logic [IW-1:0] instruction;
    logic          busy;
    logic          done;
    logic [$clog2(DEPTH):0] fifo_level;

    // stimulus controls
    logic pause_rand = 1'b0, pause_force = 1'b0, pause_r = 1'b0;
    logic idle_rand = 1'b0, idle_force = 1'b0, idle_r = 1'b0;
    logic resp_en = 1'b1, resp_fixed = 1'b0;

    assign pause     = pause_rand ? pause_r : pause_force;
    assign idle_flag = idle_rand ? idle_r : idle_force;

    // scoreboard
    logic [IW-1:0] exp_q[$];
    int            done_cnt_q[$];
    bit            done_tail_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int issues_total = 0;

    sa_inst_sequencer #(
        .OPCODE_BITS(OPB), .ADDR_BITS(AB), .COUNT_BITS(CB),
        .DESC_DEPTH(DEPTH), .IDLE_OPCODE(0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_opcode(desc_opcode), .desc_count(desc_count),
        .desc_addra_base(desc_addra_base), .desc_addrb_base(desc_addrb_base),
        .desc_addra_stride(desc_addra_stride), .desc_addrb_stride(desc_addrb_stride),
        .desc_wait_busy(desc_wait_busy), .desc_idle_tail(desc_idle_tail),
        .pause(pause), .flag(flag), .idle_flag(idle_flag),
        .instruction(instruction), .busy(busy), .done(done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Random pause / idle_flag sources, used only when the *_rand controls are set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pause_r = ($urandom_range(0, 4) == 0);
            idle_r  = ($urandom_range(0, 3) == 0);
        end
    end

    // Array model: flag rises a few cycles after going low, then drops again.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                repeat (resp_fixed ? 2 : $urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                flag = 1'b1;
                repeat (resp_fixed ? 0 : $urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
                @(posedge clk);
                #1;
                flag = 1'b0;
            end
        end
    end

    // Monitor: one latched instruction per flag-high episode; tail = idle episode.
    initial begin
        bit ep_active;
        bit ep_has_issue;
        int idle_eps;
        int since_done;
        logic [IW-1:0] e;
        int c;
        bit t;
        ep_active = 0; ep_has_issue = 0; idle_eps = 0; since_done = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ep_active = 0; ep_has_issue = 0; idle_eps = 0; since_done = 0;
            end else begin
                if (flag) begin
                    if (!ep_active) begin
                        ep_active = 1;
                        ep_has_issue = 0;
                    end
                    if (instruction[IW-1 -: OPB] != IDLE_OP && !ep_has_issue) begin
                        ep_has_issue = 1;
                        idle_eps = 0;
                        issues_total++;
                        since_done++;
                        if (exp_q.size() == 0) begin
                            fail_now("unexpected_instr", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("instr", 64'(instruction), 64'(e));
                        end
                    end
                end else if (ep_active) begin
                    ep_active = 0;
                    if (!ep_has_issue) idle_eps++;
                end
                if (done) begin
                    if (done_cnt_q.size() == 0) begin
                        fail_now("unexpected_done", 1, 0);
                    end else begin
                        c = done_cnt_q.pop_front();
                        t = done_tail_q.pop_front();
                        check("done_iters", 64'(since_done), 64'(c));
                        if (c != 0) check("tail_idle", 64'(idle_eps), 64'(t));
                    end
                    since_done = 0;
                    idle_eps = 0;
                end
            end
        end
    end

    task automatic push_desc(input int op, input int cnt, input int ab, input int bb,
                             input int as, input int bs, input bit wb, input bit tl);
        int k;
        logic [AB-1:0] ea;
        logic [AB-1:0] eb;
        logic [OPB-1:0] eo;
        k = 0;
        eo = op[OPB-1:0];
        desc_opcode       = eo;
        desc_count        = cnt[CB-1:0];
        desc_addra_base   = ab[AB-1:0];
        desc_addrb_base   = bb[AB-1:0];
        desc_addra_stride = as[AB-1:0];
        desc_addrb_stride = bs[AB-1:0];
        desc_wait_busy    = wb;
        desc_idle_tail    = tl;
        desc_valid        = 1'b1;
        while (!desc_ready && k < 3000) begin
            cyc(1);
            k++;
        end
        if (!desc_ready) begin
            fail_now("push_timeout", 0, 1);
            desc_valid = 1'b0;
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            ea = AB'(ab + i * as);
            eb = AB'(bb + i * bs);
            exp_q.push_back({eo, ea, eb});
        end
        done_cnt_q.push_back(cnt);
        done_tail_q.push_back(tl);
        cyc(1);
        desc_valid = 1'b0;
    endtask

    task automatic wait_issues(input int target);
        int k;
        k = 0;
        while (issues_total < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (issues_total < target) fail_now("issue_timeout", issues_total, target);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || done_cnt_q.size() != 0 || busy) && k < 20000) begin
            cyc(1);
            k++;
        end
        if (k >= 20000) fail_now("drain_timeout", exp_q.size(), 0);
        check("drain_level", 64'(fifo_level), 64'(0));
    endtask

    initial begin
        int base;
        int cnt;
        bit wb;
        bit tl;
        #2 reset_n = 1'b0;
        cyc(1);
        check("rst_instr", 64'(instruction), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ready", 64'(desc_ready), 64'(1));
        check("rst_level", 64'(fifo_level), 64'(0));
        cyc(3);
        reset_n = 1'b1;
        cyc(2);

        // Single long descriptor with tail, fixed 3-cycle flag latency
        resp_fixed = 1'b1;
        push_desc(1, 64, 0, 0, 1, 4, 0, 1);
        drain();
        resp_fixed = 1'b0;

        // Negative stride and wrap below zero
        push_desc(2, 64, 10, 251, 3, -4, 0, 0);
        push_desc(3, 2, 65534, 3, 1, 16'hFFFC, 0, 1);
        drain();

        // wait_busy: hold idle_flag high after iteration 0
        base = issues_total;
        push_desc(4, 5, 20, 40, 2, 2, 1, 0);
        wait_issues(base + 1);
        cyc(1);
        idle_force = 1'b1;
        cyc(20);
        check("waitb_hold", 64'(issues_total), 64'(base + 1));
        check("waitb_instr", 64'(instruction), 64'(0));
        idle_force = 1'b0;
        drain();

        // FIFO fill while the array stalls, first-instruction latency
        resp_en = 1'b0;
        cyc(8);
        push_desc(3, 3, 100, 200, 1, 1, 0, 0);
        check("lat_level", 64'(fifo_level), 64'(1));
        cyc(1);
        check("lat_busy", 64'(busy), 64'(1));
        check("lat_instr_load", 64'(instruction), 64'(0));
        cyc(1);
        check("lat_instr_first", 64'(instruction), {28'd0, 4'd3, 16'd100, 16'd200});
        check("lat_level_pop", 64'(fifo_level), 64'(0));
        for (int i = 1; i <= 8; i++) begin
            push_desc(i + 4, (i == 4) ? 0 : 2, i * 16, i * 32, 1, -1, 0, (i % 2) == 1);
        end
        check("full_level", 64'(fifo_level), 64'(8));
        check("full_ready", 64'(desc_ready), 64'(0));
        fork
            push_desc(15, 2, 7, 9, 5, 5, 0, 0);
            begin
                cyc(5);
                check("held_level", 64'(fifo_level), 64'(8));
                resp_en = 1'b1;
            end
        join
        drain();

        // pause at iteration 7 for 10 cycles
        base = issues_total;
        push_desc(6, 12, 300, 400, 1, 1, 0, 0);
        wait_issues(base + 8);
        cyc(1);
        pause_force = 1'b1;
        cyc(10);
        check("pause_hold", 64'(issues_total), 64'(base + 8));
        check("pause_instr", 64'(instruction), 64'(0));
        pause_force = 1'b0;
        drain();

        // reset during ACK of iteration 3
        base = issues_total;
        push_desc(7, 10, 0, 0, 1, 1, 0, 0);
        push_desc(8, 3, 0, 0, 1, 1, 0, 0);
        push_desc(9, 3, 0, 0, 1, 1, 0, 0);
        wait_issues(base + 4);
        cyc(1);
        reset_n = 1'b0;
        exp_q.delete();
        done_cnt_q.delete();
        done_tail_q.delete();
        #1;
        check("abort_instr", 64'(instruction), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_level", 64'(fifo_level), 64'(0));
        check("abort_ready", 64'(desc_ready), 64'(1));
        cyc(3);
        reset_n = 1'b1;
        cyc(30);
        check("post_reset_issues", 64'(issues_total), 64'(base + 4));
        check("post_reset_busy", 64'(busy), 64'(0));

        // Randomized descriptors with random pause and idle_flag
        pause_rand = 1'b1;
        idle_rand = 1'b1;
        for (int d = 0; d < 30; d++) begin
            cnt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            wb = ($urandom_range(0, 3) == 0);
            tl = $urandom_range(0, 1);
            if (wb && cnt == 1) tl = 1'b0;
            push_desc($urandom_range(1, 15), cnt, $urandom_range(0, 65535),
                      $urandom_range(0, 65535), $urandom_range(0, 65535),
                      $urandom_range(0, 65535), wb, tl);
            if ($urandom_range(0, 2) == 0) cyc($urandom_range(1, 20));
        end
        drain();
        pause_rand = 1'b0;
        idle_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
